// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared states, coin values and coin-bit indices for the vending controller
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RELEASE = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam int V_N  = 5;
    localparam int V_D  = 10;
    localparam int V_Q  = 25;
    localparam int V_D1 = 100;

    // Bit positions within coin = {s100, s25, s10, s5}
    localparam int C_N  = 0;
    localparam int C_D  = 1;
    localparam int C_Q  = 2;
    localparam int C_D1 = 3;

endpackage

// File: rtl/vending_ctrl_param_if.sv
// rtl/vending_ctrl_param_if.sv - coin/select/cancel inputs and credit/release outputs of the vending controller
interface vending_ctrl_param_if #(
    parameter int CW     = 8,
    parameter int N_ITEM = 4
);
    logic [3:0]        coin;
    logic [N_ITEM-1:0] sel;
    logic              cancel;
    logic [CW-1:0]     credit;
    logic [CW-1:0]     change;
    logic [N_ITEM-1:0] rel_item;
    logic              relq;
    logic              reld;
    logic              reln;
    logic              coin_reject;
    logic              insuff;
    logic [1:0]        state;

    modport master (
        output coin, sel, cancel,
        input  credit, change, rel_item, relq, reld, reln, coin_reject, insuff, state
    );

    modport slave (
        input  coin, sel, cancel,
        output credit, change, rel_item, relq, reld, reln, coin_reject, insuff, state
    );
endinterface

// File: rtl/vending_change_disp.sv
// rtl/vending_change_disp.sv - greedy quarter/dime/nickel selector for one dispense step
module vending_change_disp
    import vending_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] i_change,
    input  logic          i_start,
    output logic          o_q,
    output logic          o_d,
    output logic          o_n,
    output logic [CW-1:0] o_next,
    output logic          o_done
);
    always_comb begin
        o_q    = 1'b0;
        o_d    = 1'b0;
        o_n    = 1'b0;
        o_next = '0;
        if (i_start) begin
            if (i_change >= CW'(V_Q)) begin
                o_q    = 1'b1;
                o_next = i_change - CW'(V_Q);
            end else if (i_change >= CW'(V_D)) begin
                o_d    = 1'b1;
                o_next = i_change - CW'(V_D);
            end else if (i_change >= CW'(V_N)) begin
                o_n    = 1'b1;
                o_next = i_change - CW'(V_N);
            end
            // A sub-nickel residue falls through with o_next = 0 and is dropped
        end
    end

    assign o_done = i_start && (o_next == '0);
endmodule

// File: rtl/vending_ctrl_param.sv
// rtl/vending_ctrl_param.sv - multi-item vending FSM with credit limit, refund, timeout and coin change
module vending_ctrl_param
    import vending_pkg::*;
#(
    parameter int                   CW         = 8,
    parameter int                   N_ITEM     = 4,
    parameter logic [N_ITEM*CW-1:0] PRICES     = {8'd100, 8'd75, 8'd50, 8'd65},
    parameter int                   MAX_CREDIT = 200,
    parameter int                   TIMEOUT    = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    vending_ctrl_param_if.slave  bus
);
    localparam int            TW    = $clog2(TIMEOUT + 1);
    localparam int            IW    = (N_ITEM > 1) ? $clog2(N_ITEM) : 1;
    localparam logic [CW:0]   MAX_C = (CW + 1)'(MAX_CREDIT);
    localparam logic [TW-1:0] T_END = TW'(TIMEOUT - 1);

    state_t            r_state;
    logic [CW-1:0]     r_credit;
    logic [CW-1:0]     r_change;
    logic [N_ITEM-1:0] r_rel_item;
    logic              r_relq;
    logic              r_reld;
    logic              r_reln;
    logic              r_coin_reject;
    logic              r_insuff;
    logic [TW-1:0]     r_tmr;
    logic [IW-1:0]     r_item;

    logic [CW-1:0]     w_coin_val;
    logic              w_coin_any;
    logic              w_coin_multi;
    logic [CW:0]       w_sum;
    logic              w_coin_ok;
    logic              w_sel_one;
    logic [IW-1:0]     w_sel_idx;
    logic [CW-1:0]     w_sel_price;
    logic [CW-1:0]     w_item_price;
    logic              w_timeout;
    logic [TW-1:0]     w_tmr_inc;
    logic              w_disp_q;
    logic              w_disp_d;
    logic              w_disp_n;
    logic [CW-1:0]     w_disp_next;
    logic              w_disp_done;

    always_comb begin
        w_coin_val = '0;
        if (bus.coin[C_D1])     w_coin_val = CW'(V_D1);
        else if (bus.coin[C_Q]) w_coin_val = CW'(V_Q);
        else if (bus.coin[C_D]) w_coin_val = CW'(V_D);
        else if (bus.coin[C_N]) w_coin_val = CW'(V_N);
    end

    assign w_coin_any   = |bus.coin;
    assign w_coin_multi = (bus.coin & (bus.coin - 4'd1)) != 4'd0;
    assign w_sum        = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_ok    = w_coin_any && (w_sum <= MAX_C);

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < N_ITEM; i++) begin
            if (bus.sel[i]) w_sel_idx = IW'(i);
        end
    end

    assign w_sel_one    = (bus.sel != '0) && ((bus.sel & (bus.sel - N_ITEM'(1))) == '0);
    assign w_sel_price  = PRICES[w_sel_idx*CW +: CW];
    assign w_item_price = PRICES[r_item*CW +: CW];

    // Held at the threshold so a rejected coin cannot push the counter past it
    assign w_timeout = (r_tmr >= T_END);
    assign w_tmr_inc = w_timeout ? r_tmr : r_tmr + TW'(1);

    vending_change_disp #(.CW(CW)) u_disp (
        .i_change (r_change),
        .i_start  (r_state == CHANGE),
        .o_q      (w_disp_q),
        .o_d      (w_disp_d),
        .o_n      (w_disp_n),
        .o_next   (w_disp_next),
        .o_done   (w_disp_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_change      <= '0;
            r_rel_item    <= '0;
            r_relq        <= 1'b0;
            r_reld        <= 1'b0;
            r_reln        <= 1'b0;
            r_coin_reject <= 1'b0;
            r_insuff      <= 1'b0;
            r_tmr         <= '0;
            r_item        <= '0;
        end else begin
            r_rel_item    <= '0;
            r_relq        <= 1'b0;
            r_reld        <= 1'b0;
            r_reln        <= 1'b0;
            r_coin_reject <= 1'b0;
            r_insuff      <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tmr <= '0;
                    if (w_coin_any) begin
                        r_coin_reject <= w_coin_multi || !w_coin_ok;
                        if (w_coin_ok) begin
                            r_credit <= w_sum[CW-1:0];
                            r_state  <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (w_coin_any) begin
                        r_coin_reject <= w_coin_multi || !w_coin_ok;
                        if (w_coin_ok) begin
                            r_credit <= w_sum[CW-1:0];
                            r_tmr    <= '0;
                        end else begin
                            r_tmr <= w_tmr_inc;
                        end
                    end else if (bus.cancel || w_timeout) begin
                        r_change <= r_credit;
                        r_credit <= '0;
                        r_tmr    <= '0;
                        r_state  <= CHANGE;
                    end else begin
                        r_tmr <= w_tmr_inc;
                        if (w_sel_one) begin
                            if (r_credit >= w_sel_price) begin
                                r_item  <= w_sel_idx;
                                r_state <= RELEASE;
                            end else begin
                                r_insuff <= 1'b1;
                            end
                        end
                    end
                end
                RELEASE: begin
                    r_coin_reject <= w_coin_any;
                    r_rel_item    <= N_ITEM'(1) << r_item;
                    r_change      <= r_credit - w_item_price;
                    r_credit      <= '0;
                    r_state       <= (r_credit != w_item_price) ? CHANGE : IDLE;
                end
                CHANGE: begin
                    r_coin_reject <= w_coin_any;
                    r_relq        <= w_disp_q;
                    r_reld        <= w_disp_d;
                    r_reln        <= w_disp_n;
                    r_change      <= w_disp_next;
                    if (w_disp_done) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.credit      = r_credit;
    assign bus.change      = r_change;
    assign bus.rel_item    = r_rel_item;
    assign bus.relq        = r_relq;
    assign bus.reld        = r_reld;
    assign bus.reln        = r_reln;
    assign bus.coin_reject = r_coin_reject;
    assign bus.insuff      = r_insuff;
    assign bus.state       = r_state;
endmodule
